// File: rtl/ccr_unit.sv
// Condition-code register for the Execute stage: holds {C, N, Z}, feeds them
// back to the ALU, resolves conditional jumps against the held flags, and keeps
// a one-entry shadow copy for interrupt entry / RTI.
module ccr_unit #(
  parameter int FLAG_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flags_we,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic              jmp_valid,
  input  logic [1:0]        jmp_type,
  input  logic              int_save,
  input  logic              rti_restore,
  output logic [FLAG_W-1:0] flags_old,
  output logic              take_branch,
  output logic              save_valid,
  output logic              save_ovf
);

  // Bit positions inside the flag vector
  localparam int BIT_Z = 0;
  localparam int BIT_N = 1;
  localparam int BIT_C = 2;

  typedef enum logic [1:0] {
    JMP_NONE = 2'b00,
    JMP_Z    = 2'b01,
    JMP_N    = 2'b10,
    JMP_C    = 2'b11
  } jmp_kind_t;

  logic [FLAG_W-1:0] flags_q;
  logic [FLAG_W-1:0] shadow_q;
  logic [FLAG_W-1:0] flags_nx;
  logic [FLAG_W-1:0] clear_mask;
  logic              do_restore;

  assign flags_old = flags_q;

  // Decide the jump from registered flags only, and pick which bit a taken jump clears
  always_comb begin
    take_branch = 1'b0;
    clear_mask  = '0;
    unique case (jmp_kind_t'(jmp_type))
      JMP_Z: begin
        take_branch       = jmp_valid & flags_q[BIT_Z];
        clear_mask[BIT_Z] = 1'b1;
      end
      JMP_N: begin
        take_branch       = jmp_valid & flags_q[BIT_N];
        clear_mask[BIT_N] = 1'b1;
      end
      JMP_C: begin
        take_branch       = jmp_valid & flags_q[BIT_C];
        clear_mask[BIT_C] = 1'b1;
      end
      default: begin
        take_branch = 1'b0;
        clear_mask  = '0;
      end
    endcase
  end

  // Next flag value: an ALU write wins over a same-cycle jump clear
  always_comb begin
    flags_nx = flags_q;
    if (flags_we) begin
      flags_nx = flags_in;
    end else if (take_branch) begin
      flags_nx = flags_q & ~clear_mask;
    end
  end

  // A restore only counts when the shadow actually holds a saved copy
  assign do_restore = rti_restore & save_valid;

  // Flag, shadow and save-status registers; stall freezes everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q    <= '0;
      shadow_q   <= '0;
      save_valid <= 1'b0;
      save_ovf   <= 1'b0;
    end else if (!stall) begin
      if (do_restore) begin
        flags_q    <= shadow_q;
        save_valid <= 1'b0;
      end else begin
        flags_q <= flags_nx;
        if (int_save) begin
          shadow_q   <= flags_nx;
          save_valid <= 1'b1;
          if (save_valid) begin
            save_ovf <= 1'b1;
          end
        end
      end
    end
  end

endmodule
